// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed program image over
// a byte stream, writes it into instruction RAM and holds the CPU in reset
// until the image is verified. It then serves combinational instruction fetches.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
  parameter int          TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  input  logic [31:0]       pc,
  output logic [31:0]       inst,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [31:0]      DEPTH_U  = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        len_hi_reg;
  logic [ADDR_W:0]   length_reg;
  logic [ADDR_W-1:0] word_idx_reg;
  logic [1:0]        byte_idx_reg;
  logic [7:0]        csum_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic [ADDR_W:0]   word_count_reg;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              tmo_active;
  logic              timed_out;
  logic [15:0]       len_full;
  logic              len_bad;
  logic [ADDR_W:0]   len_m1;
  logic              last_word;
  logic              csum_ok;
  logic              ram_we;
  logic [31:0]       wr_word;
  logic [29:0]       fetch_word;
  logic              fetch_hit;

  assign accept     = rx_valid && rx_ready;
  assign tmo_active = (state_reg == S_LEN1) || (state_reg == S_DATA) || (state_reg == S_CSUM);
  assign timed_out  = tmo_active && (tmo_cnt_reg == TMO_LAST);
  assign len_full   = {len_hi_reg, rx_byte};
  assign len_bad    = (len_full == 16'd0) || (32'(len_full) > DEPTH_U);
  assign len_m1     = length_reg - 1'b1;
  assign last_word  = (byte_idx_reg == 2'd3) && ({1'b0, word_idx_reg} == len_m1);
  assign csum_ok    = (rx_byte == csum_reg);
  assign ram_we     = (state_reg == S_DATA) && accept && (byte_idx_reg == 2'd3);
  assign word_count = word_count_reg;

  // State register; reset abandons any partial image.
  always_ff @(posedge clk) begin
    if (!reset) state_reg <= S_LEN0;
    else        state_reg <= state_next;
  end

  // Next-state logic: stream parsing, length/checksum verdicts and idle timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_LEN0: if (accept) state_next = S_LEN1;
      S_LEN1: begin
        if (accept)         state_next = len_bad ? S_ERR : S_DATA;
        else if (timed_out) state_next = S_ERR;
      end
      S_DATA: begin
        if (accept) begin
          if (last_word) state_next = S_CSUM;
        end else if (timed_out) begin
          state_next = S_ERR;
        end
      end
      S_CSUM: begin
        if (accept)         state_next = csum_ok ? S_RUN : S_ERR;
        else if (timed_out) state_next = S_ERR;
      end
      default: ;
    endcase
  end

  // Output decode purely from the registered state, so nothing here depends on rx_*.
  always_comb begin
    rx_ready  = 1'b0;
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (state_reg)
      S_LEN0, S_LEN1, S_DATA, S_CSUM: rx_ready = 1'b1;
      S_RUN: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      S_ERR:   load_err = 1'b1;
      default: ;
    endcase
  end

  // Loader datapath: length capture, word/byte indices, running XOR, idle counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_hi_reg     <= '0;
      length_reg     <= '0;
      word_idx_reg   <= '0;
      byte_idx_reg   <= '0;
      csum_reg       <= '0;
      tmo_cnt_reg    <= '0;
      word_count_reg <= '0;
    end else begin
      if (!tmo_active || accept) tmo_cnt_reg <= '0;
      else                       tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      if (accept) begin
        case (state_reg)
          S_LEN0: len_hi_reg <= rx_byte;
          S_LEN1: length_reg <= len_full[ADDR_W:0];
          S_DATA: begin
            csum_reg     <= csum_reg ^ rx_byte;
            byte_idx_reg <= byte_idx_reg + 1'b1;
            if (byte_idx_reg == 2'd3) word_idx_reg <= word_idx_reg + 1'b1;
          end
          S_CSUM: if (csum_ok) word_count_reg <= length_reg;
          default: ;
        endcase
      end
    end
  end

  // Word assembly: lanes 0..2 are held in registers, lane 3 is the byte
  // arriving on the writing edge, so the word goes to RAM with no extra cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < 3) begin : g_store
        logic [7:0] lane_reg;
        // Capture the incoming byte into its little-endian lane.
        always_ff @(posedge clk) begin
          if (!reset)
            lane_reg <= '0;
          else if ((state_reg == S_DATA) && accept && (byte_idx_reg == 2'(gi)))
            lane_reg <= rx_byte;
        end
        assign wr_word[gi*8 +: 8] = lane_reg;
      end else begin : g_live
        assign wr_word[gi*8 +: 8] = rx_byte;
      end
    end
  endgenerate

  // Instruction RAM write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (reset && ram_we) mem[word_idx_reg] <= wr_word;
  end

  // Fetch: word offset from TEXT_BASE (word-aligned base), gated so that
  // misaligned, below-base and beyond-image fetches return a NOP.
  assign fetch_word = pc[31:2] - TEXT_BASE[31:2];
  assign fetch_hit  = (state_reg == S_RUN) && (pc >= TEXT_BASE) && (pc[1:0] == 2'b00) &&
                      (fetch_word < 30'(word_count_reg));
  assign inst       = fetch_hit ? mem[fetch_word[ADDR_W-1:0]] : 32'h0000_0000;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed image loads checked every cycle against a
// byte-history model of the image rules, plus literal fetch expectations.
module tb_imem_loader;

  localparam int          DEPTH  = 1024;
  localparam int          ADDR_W = 10;
  localparam logic [31:0] BASE   = 32'h0040_0000;
  localparam int          TO     = 16;

  logic              clk;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_ready;
  logic [31:0]       pc;
  logic [31:0]       inst;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   word_count;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TEXT_BASE(BASE), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rx_ready), .pc(pc), .inst(inst), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  typedef enum {M_LOAD, M_RUN, M_ERR} mstat_t;
  mstat_t      m_stat = M_LOAD;
  logic [7:0]  m_hist[$];
  int          m_idle = 0;
  int          m_count = 0;
  logic [31:0] m_img [int];
  bit          started = 0;

  // Judge the byte history accepted so far against the image format.
  function automatic void m_eval();
    int sz;
    int n;
    logic [7:0] x;
    sz = m_hist.size();
    n = (sz >= 2) ? int'({m_hist[0], m_hist[1]}) : 0;
    if (sz == 2) begin
      if (n == 0 || n > DEPTH) m_stat = M_ERR;
    end else if (sz == 2 + 4 * n + 1) begin
      x = 8'h00;
      for (int i = 2; i < 2 + 4 * n; i++) x = x ^ m_hist[i];
      if (x == m_hist[sz-1]) begin
        m_stat = M_RUN;
        m_count = n;
        m_img.delete();
        for (int w = 0; w < n; w++)
          m_img[w] = {m_hist[2+4*w+3], m_hist[2+4*w+2], m_hist[2+4*w+1], m_hist[2+4*w]};
      end else begin
        m_stat = M_ERR;
      end
    end
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] p);
    logic [31:0] off;
    off = p - BASE;
    if (m_stat == M_RUN && p >= BASE && p[1:0] == 2'b00 && (off >> 2) < 32'(m_count))
      return m_img[int'(off >> 2)];
    return 32'h0;
  endfunction

  // Model update on every rising edge.
  always @(posedge clk) begin
    if (!reset) begin
      started = 1;
      m_hist.delete();
      m_idle  = 0;
      m_stat  = M_LOAD;
      m_count = 0;
    end else if (started && m_stat == M_LOAD) begin
      if (rx_valid) begin
        m_hist.push_back(rx_byte);
        m_idle = 0;
        m_eval();
      end else if (m_hist.size() > 0) begin
        m_idle++;
        if (m_idle >= TO) m_stat = M_ERR;
      end
    end
  end

  // ---------------- comparison ----------------
  logic        lit_en = 1'b0;
  logic [31:0] lit_inst;
  logic        lit_rdy, lit_hold, lit_done, lit_err;
  int          lit_wc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Mid-cycle compare of every output against the model, plus literals when armed.
  always @(negedge clk) begin
    if (started) begin
      chk("rx_ready",   32'(rx_ready),   32'(m_stat == M_LOAD));
      chk("cpu_hold",   32'(cpu_hold),   32'(m_stat != M_RUN));
      chk("load_done",  32'(load_done),  32'(m_stat == M_RUN));
      chk("load_err",   32'(load_err),   32'(m_stat == M_ERR));
      chk("word_count", 32'(word_count), 32'(m_count));
      chk("inst",       inst,            exp_inst(pc));
      if (lit_en) begin
        chk("lit_inst",  inst,            lit_inst);
        chk("lit_rdy",   32'(rx_ready),   32'(lit_rdy));
        chk("lit_hold",  32'(cpu_hold),   32'(lit_hold));
        chk("lit_done",  32'(load_done),  32'(lit_done));
        chk("lit_err",   32'(load_err),   32'(lit_err));
        chk("lit_wc",    32'(word_count), 32'(lit_wc));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    $display("send byte %02h", b);
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    $display("reset pulse");
  endtask

  task automatic lit_check(input logic [31:0] p, input logic [31:0] i, input logic r,
                           input logic h, input logic d, input logic e, input int w);
    pc = p; lit_inst = i; lit_rdy = r; lit_hold = h; lit_done = d; lit_err = e; lit_wc = w;
    lit_en = 1'b1;
    tick();
    lit_en = 1'b0;
    $display("check pc=%08h expect inst=%08h done=%0b err=%0b wc=%0d", p, i, d, e, w);
  endtask

  logic [7:0] img[$];

  initial begin
    reset = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; pc = BASE;
    repeat (2) tick();
    reset = 1'b1;

    // Normal two-word load; payload XOR is 0x38.
    img = '{8'h00, 8'h02, 8'h20, 8'h00, 8'h08, 8'h3C, 8'h01, 8'h00, 8'h08, 8'h25, 8'h38};
    send_q(img);
    lit_check(BASE,          32'h3C080020, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    lit_check(BASE + 32'd4,  32'h25080001, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    lit_check(BASE + 32'd8,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 2);
    lit_check(BASE + 32'd2,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 2);
    lit_check(32'h003FFFFC,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 2);

    // Stream noise while running must change nothing.
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'b1;
      rx_byte  = 8'($urandom);
      pc       = BASE + 32'(4 * (i % 3));
      tick();
      $display("run-noise byte %02h pc=%08h", rx_byte, pc);
    end
    rx_valid = 1'b0;
    lit_check(BASE, 32'h3C080020, 1'b0, 1'b0, 1'b1, 1'b0, 2);

    // Zero length.
    do_reset();
    send(8'h00); send(8'h00);
    lit_check(BASE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 0);

    // Length one beyond DEPTH.
    do_reset();
    send(8'h04); send(8'h01);
    lit_check(BASE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 0);

    // Bad checksum.
    do_reset();
    img = '{8'h00, 8'h02, 8'h20, 8'h00, 8'h08, 8'h3C, 8'h01, 8'h00, 8'h08, 8'h25, 8'h11};
    send_q(img);
    lit_check(BASE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 0);

    // Timeout: error exactly 16 edges after the last accept.
    do_reset();
    send(8'h00); send(8'h01); send(8'h20);
    repeat (TO - 1) tick();
    lit_check(BASE, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    lit_check(BASE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 0);

    // Gaps of TIMEOUT-1 idle cycles are tolerated.
    do_reset();
    img = '{8'h00, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20};
    foreach (img[i]) begin
      send(img[i]);
      if (i < img.size() - 1) repeat (TO - 1) tick();
    end
    lit_check(BASE, 32'h00000020, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // Reset mid-load, with a byte offered on the reset cycle itself.
    do_reset();
    send(8'h00); send(8'h02); send(8'hAA); send(8'hBB); send(8'hCC);
    reset = 1'b0; rx_valid = 1'b1; rx_byte = 8'h00;
    tick();
    reset = 1'b1; rx_valid = 1'b0;
    $display("reset pulse with byte offered");
    lit_check(BASE, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    img = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    send_q(img);
    lit_check(BASE,         32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    lit_check(BASE + 32'd4, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
